// File: rtl/irq_sequencer.sv
// irq_sequencer: arbitrates reset, NMI, BRK and IRQ entry and steps the shared
// datapath through push PCH / push PCL / push P / vector low / vector high.
// While a sequence runs the decoder is held off (busy) and its controls are
// overridden by the strobes below.
module irq_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  input  logic        brk_req,
  input  logic        instr_done,
  output logic        busy,
  output logic        flush,
  output logic        w_rd,
  output logic [1:0]  addr_sel,
  output logic [1:0]  data_sel,
  output logic        sp_dec,
  output logic        pc_load_lo,
  output logic        pc_load_hi,
  output logic        set_i,
  output logic        b_flag,
  output logic [15:0] vec_addr
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_VEC_LO,
    S_VEC_HI
  } state_t;

  typedef enum logic [1:0] {
    K_RST,
    K_NMI,
    K_BRK,
    K_IRQ
  } kind_t;

  state_t      r_state;
  state_t      w_state_nxt;
  kind_t       r_kind;
  kind_t       w_kind_nxt;
  logic        r_nmi_pend;
  logic        r_nmi_q;
  logic        w_nmi_edge;
  logic        w_nmi_clr;
  logic        w_irq_req;
  logic        w_brk_or_irq;
  logic [15:0] w_vec_base;

  // NMI is edge-triggered: a rising edge is remembered until it is serviced,
  // whatever the sequencer happens to be doing at the time.
  assign w_nmi_edge   = nmi & ~r_nmi_q;
  assign w_irq_req    = irq & ~i_flag;
  assign w_brk_or_irq = (r_kind == K_BRK) || (r_kind == K_IRQ);

  // State, entry kind and NMI latch; reset parks the sequencer in HOLD.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HOLD;
      r_kind     <= K_RST;
      r_nmi_pend <= 1'b0;
      r_nmi_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_nmi_q    <= nmi;
      // A fresh edge wins over a clear in the same cycle: it is a new request.
      r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
    end
  end

  // Next state: arbitration at instruction boundaries and NMI hijack in PUSH_P.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_nmi_clr   = 1'b0;
    unique case (r_state)
      S_HOLD: begin
        w_state_nxt = S_PUSH_PCH;
        w_kind_nxt  = K_RST;
      end
      S_IDLE: begin
        if (instr_done) begin
          if (r_nmi_pend) begin
            w_kind_nxt  = K_NMI;
            w_nmi_clr   = 1'b1;
            w_state_nxt = S_PUSH_PCH;
          end else if (brk_req) begin
            w_kind_nxt  = K_BRK;
            w_state_nxt = S_PUSH_PCH;
          end else if (w_irq_req) begin
            w_kind_nxt  = K_IRQ;
            w_state_nxt = S_PUSH_PCH;
          end
        end
      end
      S_PUSH_PCH: w_state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: w_state_nxt = S_PUSH_P;
      S_PUSH_P: begin
        // A pending NMI redirects a BRK/IRQ entry to the NMI vector; the
        // status byte already pushed keeps the original B bit.
        if (r_nmi_pend && w_brk_or_irq) begin
          w_kind_nxt = K_NMI;
          w_nmi_clr  = 1'b1;
        end
        w_state_nxt = S_VEC_LO;
      end
      S_VEC_LO: w_state_nxt = S_VEC_HI;
      S_VEC_HI: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_HOLD;
    endcase
  end

  // Vector base selected by the (possibly hijacked) entry kind.
  always_comb begin
    unique case (r_kind)
      K_NMI:   w_vec_base = NMI_VEC;
      K_RST:   w_vec_base = RST_VEC;
      default: w_vec_base = IRQ_VEC;
    endcase
  end

  // Datapath controls decoded purely from state and kind, so an async reset
  // drops every strobe as soon as the state register is cleared.
  always_comb begin
    busy       = 1'b1;
    flush      = 1'b0;
    w_rd       = 1'b0;
    addr_sel   = 2'd0;
    data_sel   = 2'd0;
    sp_dec     = 1'b0;
    pc_load_lo = 1'b0;
    pc_load_hi = 1'b0;
    set_i      = 1'b0;
    b_flag     = 1'b0;
    vec_addr   = 16'h0000;
    unique case (r_state)
      S_HOLD: ;
      S_IDLE: busy = 1'b0;
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        addr_sel = 2'd1;
        sp_dec   = 1'b1;
        // Reset entry performs dummy reads while still walking SP down.
        w_rd     = (r_kind != K_RST);
        if (r_state == S_PUSH_PCL) data_sel = 2'd1;
        if (r_state == S_PUSH_P) begin
          data_sel = 2'd2;
          b_flag   = (r_kind == K_BRK);
        end
      end
      S_VEC_LO: begin
        addr_sel   = 2'd2;
        pc_load_lo = 1'b1;
        set_i      = 1'b1;
        vec_addr   = w_vec_base;
      end
      S_VEC_HI: begin
        addr_sel   = 2'd2;
        pc_load_hi = 1'b1;
        flush      = 1'b1;
        vec_addr   = w_vec_base + 16'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scenarios followed by randomized traffic, with
// every cycle's outputs compared against a cycle-count reference model.
module tb_irq_sequencer;

  localparam int K_RST = 0;
  localparam int K_NMI = 1;
  localparam int K_BRK = 2;
  localparam int K_IRQ = 3;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic        nmi = 1'b0;
  logic        irq = 1'b0;
  logic        i_flag = 1'b0;
  logic        brk_req = 1'b0;
  logic        instr_done = 1'b0;
  logic        busy, flush, w_rd, sp_dec, pc_load_lo, pc_load_hi, set_i, b_flag;
  logic [1:0]  addr_sel, data_sel;
  logic [15:0] vec_addr;

  irq_sequencer dut (
    .clk_2      (clk_2),
    .rst        (rst),
    .nmi        (nmi),
    .irq        (irq),
    .i_flag     (i_flag),
    .brk_req    (brk_req),
    .instr_done (instr_done),
    .busy       (busy),
    .flush      (flush),
    .w_rd       (w_rd),
    .addr_sel   (addr_sel),
    .data_sel   (data_sel),
    .sp_dec     (sp_dec),
    .pc_load_lo (pc_load_lo),
    .pc_load_hi (pc_load_hi),
    .set_i      (set_i),
    .b_flag     (b_flag),
    .vec_addr   (vec_addr)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: m_step counts cycles into the 5-cycle entry sequence
  // (-1 = waiting at instruction boundaries), m_hold marks the post-reset cycle.
  bit m_hold = 1'b1;
  int m_step = -1;
  int m_kind = K_RST;
  bit m_pend = 1'b0;
  bit m_prev = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          n_seq = 0;
  logic [15:0] seen_lo, seen_hi;
  logic        seen_b;

  function automatic logic [15:0] vec_base(input int kind);
    if (kind == K_NMI) return 16'hFFFA;
    if (kind == K_RST) return 16'hFFFC;
    return 16'hFFFE;
  endfunction

  // {busy, flush, w_rd, addr_sel, data_sel, sp_dec, pc_load_lo, pc_load_hi,
  //  set_i, b_flag, vec_addr}
  function automatic logic [27:0] model_out();
    if (!rst || m_hold) return {1'b1, 27'b0};
    if (m_step < 0) return 28'b0;
    if (m_step <= 2)
      return {1'b1, 1'b0, (m_kind != K_RST), 2'd1, 2'(m_step), 1'b1, 1'b0, 1'b0,
              1'b0, (m_step == 2 && m_kind == K_BRK), 16'h0000};
    if (m_step == 3)
      return {1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
              vec_base(m_kind)};
    return {1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
            vec_base(m_kind) + 16'd1};
  endfunction

  task automatic model_reset();
    m_hold = 1'b1;
    m_step = -1;
    m_kind = K_RST;
    m_pend = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic model_clock();
    bit edge_seen;
    bit clr;
    if (!rst) return;
    edge_seen = nmi && !m_prev;
    m_prev    = nmi;
    clr       = 1'b0;
    if (m_hold) begin
      m_hold = 1'b0;
      m_step = 0;
      m_kind = K_RST;
    end else if (m_step < 0) begin
      if (instr_done) begin
        if (m_pend) begin
          m_kind = K_NMI; clr = 1'b1; m_step = 0;
        end else if (brk_req) begin
          m_kind = K_BRK; m_step = 0;
        end else if (irq && !i_flag) begin
          m_kind = K_IRQ; m_step = 0;
        end
      end
    end else if (m_step == 2) begin
      if (m_pend && (m_kind == K_BRK || m_kind == K_IRQ)) begin
        m_kind = K_NMI;
        clr    = 1'b1;
      end
      m_step = 3;
    end else if (m_step == 4) begin
      m_step = -1;
    end else begin
      m_step++;
    end
    m_pend = (m_pend && !clr) || edge_seen;
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic tick(input string tag);
    logic [27:0] obs;
    logic [27:0] exp;
    @(negedge clk_2);
    obs = {busy, flush, w_rd, addr_sel, data_sel, sp_dec, pc_load_lo, pc_load_hi,
           set_i, b_flag, vec_addr};
    exp = model_out();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp);
    end
    if (pc_load_lo === 1'b1) seen_lo = vec_addr;
    if (pc_load_hi === 1'b1) seen_hi = vec_addr;
    if (flush === 1'b1) n_seq++;
    if (sp_dec === 1'b1 && data_sel === 2'd2) seen_b = b_flag;
    @(posedge clk_2);
    model_clock();
    #1;
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    seen_lo = 16'h0000;
    seen_hi = 16'h0000;
    seen_b  = 1'bx;
  endtask

  task automatic pull_reset();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n0;
    clear_seen();
    #2 pull_reset();

    // Power-on reset: 3 cycles low, one HOLD cycle, dummy pushes, FFFC/FFFD.
    repeat (3) tick("reset_low");
    rst = 1'b1;
    tick("reset_hold");
    repeat (5) tick("reset_seq");
    check_val("reset_vec_lo", seen_lo, 16'hFFFC);
    check_val("reset_vec_hi", seen_hi, 16'hFFFD);
    tick("reset_idle");

    // IRQ with I clear.
    clear_seen();
    irq = 1'b1; i_flag = 1'b0; instr_done = 1'b1;
    tick("irq_accept");
    irq = 1'b0; instr_done = 1'b0;
    repeat (5) tick("irq_seq");
    check_val("irq_vec_lo", seen_lo, 16'hFFFE);
    check_val("irq_vec_hi", seen_hi, 16'hFFFF);
    check_val("irq_b_flag", 16'(seen_b), 16'h0000);

    // IRQ masked by I.
    n0 = n_seq;
    irq = 1'b1; i_flag = 1'b1; instr_done = 1'b1;
    repeat (8) tick("irq_masked");
    check_val("irq_masked_count", 16'(n_seq - n0), 16'h0000);
    irq = 1'b0; i_flag = 1'b0; instr_done = 1'b0;

    // BRK beats a simultaneous IRQ.
    clear_seen();
    brk_req = 1'b1; irq = 1'b1; instr_done = 1'b1;
    tick("brk_accept");
    brk_req = 1'b0; irq = 1'b0; instr_done = 1'b0;
    repeat (5) tick("brk_seq");
    check_val("brk_b_flag", 16'(seen_b), 16'h0001);
    check_val("brk_vec_lo", seen_lo, 16'hFFFE);

    // NMI edge waits for a boundary; a held-high line does not retrigger.
    clear_seen();
    nmi = 1'b1;
    repeat (4) tick("nmi_wait");
    instr_done = 1'b1;
    tick("nmi_accept");
    instr_done = 1'b0;
    repeat (5) tick("nmi_seq");
    check_val("nmi_vec_lo", seen_lo, 16'hFFFA);
    check_val("nmi_vec_hi", seen_hi, 16'hFFFB);
    n0 = n_seq;
    instr_done = 1'b1;
    repeat (6) tick("nmi_held");
    check_val("nmi_no_retrigger", 16'(n_seq - n0), 16'h0000);
    instr_done = 1'b0; nmi = 1'b0;
    tick("nmi_low");

    // NMI hijacks a BRK sequence when it rises during PUSH_PCL.
    clear_seen();
    brk_req = 1'b1; instr_done = 1'b1;
    tick("hijack_accept");
    brk_req = 1'b0; instr_done = 1'b0;
    tick("hijack_pch");
    nmi = 1'b1;
    tick("hijack_pcl");
    repeat (3) tick("hijack_tail");
    check_val("hijack_b_flag", 16'(seen_b), 16'h0001);
    check_val("hijack_vec_lo", seen_lo, 16'hFFFA);
    check_val("hijack_vec_hi", seen_hi, 16'hFFFB);
    n0 = n_seq;
    instr_done = 1'b1;
    repeat (4) tick("hijack_pend_clear");
    check_val("hijack_no_second", 16'(n_seq - n0), 16'h0000);
    instr_done = 1'b0; nmi = 1'b0;

    // Reset asserted during PUSH_P of an IRQ sequence.
    clear_seen();
    irq = 1'b1; instr_done = 1'b1;
    tick("rstmid_accept");
    irq = 1'b0; instr_done = 1'b0;
    repeat (2) tick("rstmid_push");
    pull_reset();
    repeat (2) tick("rstmid_low");
    rst = 1'b1;
    tick("rstmid_hold");
    repeat (5) tick("rstmid_seq");
    check_val("rstmid_vec_lo", seen_lo, 16'hFFFC);
    check_val("rstmid_vec_hi", seen_hi, 16'hFFFD);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      irq        = 1'($urandom_range(0, 1));
      i_flag     = ($urandom_range(0, 3) == 0);
      brk_req    = ($urandom_range(0, 3) == 0);
      instr_done = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) nmi = ~nmi;
      if (rst && $urandom_range(0, 199) == 0) pull_reset();
      else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
